// File: rtl/add_arb_pkg.sv
// add_arb_pkg: shared types for the add_wrap arbiter (FSM states, tag, operand).
package add_arb_pkg;
   localparam int TAG_W = 3;
   typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_DONE} state_e;
   typedef logic [TAG_W-1:0] tag_t;
   typedef logic [63:0] op_t;
endpackage

// File: rtl/add_arb_tagq.sv
// add_arb_tagq: synchronous tag FIFO remembering which requester owns each in-flight add.
module add_arb_tagq
   import add_arb_pkg::*;
#(
   parameter int DEPTH = 32
) (
   input  logic ck,
   input  logic rst,
   input  logic push,
   input  logic pop,
   input  tag_t wr_tag,
   output tag_t rd_tag,
   output logic empty,
   output logic full
);
   localparam int AW = $clog2(DEPTH);
   logic [AW:0] wp_q, wp_d, rp_q, rp_d;
   tag_t mem_q [DEPTH];
   always_comb begin
      wp_d = push ? wp_q + (AW+1)'(1) : wp_q;
      rp_d = pop ? rp_q + (AW+1)'(1) : rp_q;
   end
   always_ff @(posedge ck or negedge rst) begin
      if (!rst) begin
         wp_q <= '0;
         rp_q <= '0;
      end else begin
         wp_q <= wp_d;
         rp_q <= rp_d;
      end
   end
   always_ff @(posedge ck) begin
      if (push) mem_q[wp_q[AW-1:0]] <= wr_tag;
   end
   assign rd_tag = mem_q[rp_q[AW-1:0]];
   assign empty  = wp_q == rp_q;
   assign full   = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
endmodule

// File: rtl/add_arb.sv
// add_arb: round-robin arbiter sharing one add_wrap among NREQ requesters, with drain.
// Defining ADD_ARB_STATS_EN adds stat_grant/stat_stall counters.
module add_arb
   import add_arb_pkg::*;
#(
   parameter int NREQ    = 4,
   parameter int MAX_OUT = 32
) (
   input  logic              ck,
   input  logic              rst,
   input  logic [NREQ-1:0]   req_vld,
   input  logic [NREQ*64-1:0] req_a,
   input  logic [NREQ*64-1:0] req_b,
   output logic [NREQ-1:0]   req_rdy,
   output logic              add_vld,
   output logic [63:0]       add_a,
   output logic [63:0]       add_b,
   input  logic              add_rdy,
   input  logic              add_res_vld,
   input  logic [63:0]       add_res,
   output logic [NREQ-1:0]   rsp_vld,
   output logic [63:0]       rsp_res,
   input  logic              drain_req,
   output logic              drain_ack,
   output logic              err
`ifdef ADD_ARB_STATS_EN
   ,
   output logic [NREQ*32-1:0] stat_grant,
   output logic [31:0]        stat_stall
`endif
);
   localparam int CW = $clog2(MAX_OUT) + 1;
   localparam logic [CW-1:0] FULL_C = CW'(MAX_OUT);
   state_e state_q, state_d;
   tag_t ptr_q, ptr_d, gnt_tag, pop_tag;
   logic [CW-1:0] out_q, out_d;
   logic err_q, err_d, add_vld_q, add_vld_d, xfer, pop, q_empty, q_full, can_gnt;
   op_t add_a_q, add_a_d, add_b_q, add_b_d, rsp_res_q, rsp_res_d, sel_a, sel_b;
   logic [NREQ-1:0] rsp_vld_q, rsp_vld_d, rdy;
   logic [2*NREQ-1:0] rot;
   // Rotate requests so bit 0 is the pointer; the lowest set bit wins.
   always_comb begin
      can_gnt = state_q == ST_RUN && !drain_req && add_rdy && out_q < FULL_C && !q_full;
      rot = {req_vld, req_vld} >> ptr_q;
      gnt_tag = '0;
      for (int k = NREQ - 1; k >= 0; k--)
         if (rot[k]) gnt_tag = tag_t'((int'(ptr_q) + k) % NREQ);
      sel_a = '0;
      sel_b = '0;
      for (int k = 0; k < NREQ; k++) begin
         rdy[k] = can_gnt && (|req_vld) && gnt_tag == tag_t'(k);
         sel_a = sel_a | ({64{rdy[k]}} & req_a[64*k +: 64]);
         sel_b = sel_b | ({64{rdy[k]}} & req_b[64*k +: 64]);
      end
      xfer = |rdy;
   end
   always_comb begin
      pop = add_res_vld && !q_empty;
      err_d = err_q | (add_res_vld && q_empty);
      out_d = out_q + CW'(xfer) - CW'(pop);
      ptr_d = xfer ? ((gnt_tag == tag_t'(NREQ - 1)) ? '0 : gnt_tag + tag_t'(1)) : ptr_q;
      add_vld_d = xfer;
      add_a_d = xfer ? sel_a : add_a_q;
      add_b_d = xfer ? sel_b : add_b_q;
      for (int k = 0; k < NREQ; k++) rsp_vld_d[k] = pop && pop_tag == tag_t'(k);
      rsp_res_d = pop ? add_res : rsp_res_q;
      state_d = (state_q == ST_RUN && drain_req) ? ST_DRAIN :
                (state_q == ST_DRAIN && out_q == '0 && !add_vld_q) ? ST_DONE :
                (state_q == ST_DONE && !drain_req) ? ST_RUN : state_q;
   end
   always_ff @(posedge ck or negedge rst) begin
      if (!rst) begin
         state_q   <= ST_RUN;
         ptr_q     <= '0;
         out_q     <= '0;
         err_q     <= 1'b0;
         add_vld_q <= 1'b0;
         add_a_q   <= '0;
         add_b_q   <= '0;
         rsp_vld_q <= '0;
         rsp_res_q <= '0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         out_q     <= out_d;
         err_q     <= err_d;
         add_vld_q <= add_vld_d;
         add_a_q   <= add_a_d;
         add_b_q   <= add_b_d;
         rsp_vld_q <= rsp_vld_d;
         rsp_res_q <= rsp_res_d;
      end
   end
   add_arb_tagq #(.DEPTH(MAX_OUT)) u_tagq (
      .ck    (ck),
      .rst   (rst),
      .push  (xfer),
      .pop   (pop),
      .wr_tag(gnt_tag),
      .rd_tag(pop_tag),
      .empty (q_empty),
      .full  (q_full)
   );
`ifdef ADD_ARB_STATS_EN
   logic [NREQ*32-1:0] stat_grant_q, stat_grant_d;
   logic [31:0] stat_stall_q, stat_stall_d;
   always_comb begin
      for (int k = 0; k < NREQ; k++)
         stat_grant_d[32*k +: 32] = stat_grant_q[32*k +: 32] + 32'(rdy[k]);
      stat_stall_d = stat_stall_q + 32'((|req_vld) && !xfer);
   end
   always_ff @(posedge ck or negedge rst) begin
      if (!rst) begin
         stat_grant_q <= '0;
         stat_stall_q <= '0;
      end else begin
         stat_grant_q <= stat_grant_d;
         stat_stall_q <= stat_stall_d;
      end
   end
   assign stat_grant = stat_grant_q;
   assign stat_stall = stat_stall_q;
`endif
   assign req_rdy   = rdy;
   assign add_vld   = add_vld_q;
   assign add_a     = add_a_q;
   assign add_b     = add_b_q;
   assign rsp_vld   = rsp_vld_q;
   assign rsp_res   = rsp_res_q;
   assign drain_ack = state_q == ST_DONE;
   assign err       = err_q;
endmodule

// File: tb/tb_add_arb.sv
// tb_add_arb: randomized and directed checks of add_arb against a queue-based model.
module tb_add_arb;
   localparam int NREQ = 4;
   localparam int MAX_OUT = 32;
   logic ck = 1'b0, rst = 1'b0;
   logic [NREQ-1:0] req_vld = '0, req_rdy, rsp_vld;
   logic [NREQ*64-1:0] req_a = '0, req_b = '0;
   logic add_vld, add_rdy = 1'b0, add_res_vld = 1'b0, drain_req = 1'b0, drain_ack, err;
   logic [63:0] add_a, add_b, add_res = '0, rsp_res;
   int n_vec = 0, n_err = 0;
   int m_ptr, m_state, m_q[$];
   bit m_err, m_add_vld;
   logic [63:0] m_add_a, m_add_b, m_rsp_res;
   logic [NREQ-1:0] m_rsp_vld, obs_rdy, exp_rdy;

   always #5 ck = ~ck;

   add_arb #(.NREQ(NREQ), .MAX_OUT(MAX_OUT)) dut (
      .ck(ck), .rst(rst), .req_vld(req_vld), .req_a(req_a), .req_b(req_b), .req_rdy(req_rdy),
      .add_vld(add_vld), .add_a(add_a), .add_b(add_b), .add_rdy(add_rdy),
      .add_res_vld(add_res_vld), .add_res(add_res), .rsp_vld(rsp_vld), .rsp_res(rsp_res),
      .drain_req(drain_req), .drain_ack(drain_ack), .err(err)
   );

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   function automatic int model_grant();
      if (m_state != 0 || drain_req || !add_rdy || m_q.size() >= MAX_OUT) return -1;
      for (int k = 0; k < NREQ; k++)
         if (req_vld[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
      return -1;
   endfunction

   task automatic model_reset();
      m_ptr = 0; m_state = 0; m_q.delete(); m_err = 0; m_add_vld = 0;
      m_add_a = '0; m_add_b = '0; m_rsp_vld = '0; m_rsp_res = '0;
   endtask

   // One clock: sample the grant, advance the model, stop on the next falling edge.
   task automatic cycle();
      int g, sz, t;
      #1;
      obs_rdy = req_rdy;
      g = model_grant();
      exp_rdy = (g < 0) ? '0 : NREQ'(1 << g);
      sz = m_q.size();
      if (m_state == 0 && drain_req) m_state = 1;
      else if (m_state == 1 && sz == 0 && !m_add_vld) m_state = 2;
      else if (m_state == 2 && !drain_req) m_state = 0;
      m_rsp_vld = '0;
      if (add_res_vld) begin
         if (sz > 0) begin
            t = m_q.pop_front();
            m_rsp_vld = NREQ'(1 << t);
            m_rsp_res = add_res;
         end else m_err = 1;
      end
      m_add_vld = g >= 0;
      if (g >= 0) begin
         m_add_a = req_a[64*g +: 64];
         m_add_b = req_b[64*g +: 64];
         m_q.push_back(g);
         m_ptr = (g + 1) % NREQ;
      end
      @(posedge ck);
      @(negedge ck);
   endtask

   task automatic rand_ops();
      for (int k = 0; k < NREQ; k++) begin
         req_a[64*k +: 64] = {$urandom, $urandom};
         req_b[64*k +: 64] = {$urandom, $urandom};
      end
   endtask

   task automatic flush_results();
      int guard = 0;
      req_vld = '0;
      while (m_q.size() > 0 && guard < 100) begin
         add_res_vld = 1'b1;
         add_res = {$urandom, $urandom};
         cycle();
         guard++;
         n_vec++;
         if (rsp_vld !== m_rsp_vld || rsp_res !== m_rsp_res) begin
            n_err++;
            $display("FAIL flush_rsp: got %b/%h want %b/%h", rsp_vld, rsp_res, m_rsp_vld, m_rsp_res);
         end
      end
      add_res_vld = 1'b0;
      cycle();
   endtask

   task automatic test_reset();
      rst = 1'b0; req_vld = '1; add_rdy = 1'b1; add_res_vld = 1'b1;
      repeat (3) @(negedge ck);
      n_vec++;
      if ({add_vld, rsp_vld, drain_ack, err} !== '0 || add_a !== '0 || add_b !== '0 || rsp_res !== '0) begin
         n_err++;
         $display("FAIL reset_state: got vld=%b rsp=%b ack=%b err=%b a=%h b=%h r=%h want all 0",
                  add_vld, rsp_vld, drain_ack, err, add_a, add_b, rsp_res);
      end
      req_vld = '0; add_res_vld = 1'b0;
      model_reset();
      rst = 1'b1;
   endtask

   task automatic test_rr_order();
      int order[5] = '{0, 1, 2, 3, 0};
      req_vld = '1; add_rdy = 1'b1;
      for (int i = 0; i < 5; i++) begin
         rand_ops();
         cycle();
         n_vec++;
         if (obs_rdy !== exp_rdy || obs_rdy !== NREQ'(1 << order[i])) begin
            n_err++;
            $display("FAIL rr_grant[%0d]: got %b want %b", i, obs_rdy, NREQ'(1 << order[i]));
         end
         n_vec++;
         if (add_vld !== 1'b1 || add_a !== m_add_a || add_b !== m_add_b) begin
            n_err++;
            $display("FAIL rr_issue[%0d]: got %b %h %h want 1 %h %h", i, add_vld, add_a, add_b, m_add_a, m_add_b);
         end
      end
      req_vld = '0;
      cycle();
      n_vec++;
      if (add_vld !== 1'b0) begin
         n_err++;
         $display("FAIL rr_idle_vld: got %b want 0", add_vld);
      end
      flush_results();
   endtask

   task automatic test_route();
      req_vld = 4'b0100;
      req_a[128 +: 64] = 64'h3FF0_0000_0000_0000;
      req_b[128 +: 64] = 64'h4000_0000_0000_0000;
      cycle();
      n_vec++;
      if (obs_rdy !== 4'b0100 || add_vld !== 1'b1 || add_a !== 64'h3FF0_0000_0000_0000 || add_b !== 64'h4000_0000_0000_0000) begin
         n_err++;
         $display("FAIL route_issue: got rdy=%b vld=%b a=%h b=%h want 0100 1 3ff0.. 4000..", obs_rdy, add_vld, add_a, add_b);
      end
      req_vld = '0; add_res_vld = 1'b1; add_res = 64'h4008_0000_0000_0000;
      cycle();
      n_vec++;
      if (rsp_vld !== 4'b0100 || rsp_res !== 64'h4008_0000_0000_0000) begin
         n_err++;
         $display("FAIL route_rsp: got %b %h want 0100 4008000000000000", rsp_vld, rsp_res);
      end
      add_res_vld = 1'b0;
      cycle();
      n_vec++;
      if (rsp_vld !== '0) begin
         n_err++;
         $display("FAIL route_rsp_clear: got %b want 0000", rsp_vld);
      end
   endtask

   task automatic test_backpressure();
      add_rdy = 1'b0; req_vld = 4'b0011;
      repeat (3) begin
         cycle();
         n_vec++;
         if (obs_rdy !== '0) begin
            n_err++;
            $display("FAIL bp_blocked: got %b want 0000", obs_rdy);
         end
      end
      add_rdy = 1'b1;
      cycle();
      n_vec++;
      if (obs_rdy !== exp_rdy || obs_rdy !== 4'b0001) begin
         n_err++;
         $display("FAIL bp_resume: got %b want 0001", obs_rdy);
      end
      flush_results();
   endtask

   task automatic test_credit();
      int grants = 0, extra = 0;
      req_vld = '1; add_rdy = 1'b1;
      for (int i = 0; i < 33; i++) begin
         rand_ops();
         cycle();
         grants += $countones(obs_rdy);
         n_vec++;
         if (obs_rdy !== exp_rdy) begin
            n_err++;
            $display("FAIL credit_rdy[%0d]: got %b want %b", i, obs_rdy, exp_rdy);
         end
      end
      n_vec++;
      if (grants != MAX_OUT || obs_rdy !== '0) begin
         n_err++;
         $display("FAIL credit_limit: got %0d grants last %b want %0d and 0000", grants, obs_rdy, MAX_OUT);
      end
      add_res_vld = 1'b1; add_res = {$urandom, $urandom};
      cycle();
      extra += $countones(obs_rdy);
      add_res_vld = 1'b0;
      repeat (2) begin
         cycle();
         extra += $countones(obs_rdy);
      end
      n_vec++;
      if (extra != 1) begin
         n_err++;
         $display("FAIL credit_refill: got %0d grants want 1", extra);
      end
      flush_results();
   endtask

   task automatic test_drain();
      int guard = 0;
      req_vld = '1; add_rdy = 1'b1;
      repeat (5) cycle();
      drain_req = 1'b1;
      cycle();
      n_vec++;
      if (obs_rdy !== '0 || m_q.size() != 5) begin
         n_err++;
         $display("FAIL drain_block: got %b outstanding %0d want 0000 and 5", obs_rdy, m_q.size());
      end
      while (m_q.size() > 0 && guard < 10) begin
         add_res_vld = 1'b1; add_res = {$urandom, $urandom};
         cycle();
         guard++;
         n_vec++;
         if (obs_rdy !== '0 || drain_ack !== 1'b0 || rsp_vld !== m_rsp_vld) begin
            n_err++;
            $display("FAIL drain_busy: got rdy=%b ack=%b rsp=%b want 0000 0 %b", obs_rdy, drain_ack, rsp_vld, m_rsp_vld);
         end
      end
      add_res_vld = 1'b0;
      cycle();
      n_vec++;
      if (drain_ack !== 1'b1 || obs_rdy !== '0) begin
         n_err++;
         $display("FAIL drain_ack: got ack=%b rdy=%b want 1 0000", drain_ack, obs_rdy);
      end
      drain_req = 1'b0;
      cycle();
      n_vec++;
      if (drain_ack !== 1'b0) begin
         n_err++;
         $display("FAIL drain_release: got %b want 0", drain_ack);
      end
      cycle();
      n_vec++;
      if (obs_rdy === '0 || obs_rdy !== exp_rdy) begin
         n_err++;
         $display("FAIL drain_resume: got %b want %b", obs_rdy, exp_rdy);
      end
      flush_results();
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         req_vld = NREQ'($urandom);
         rand_ops();
         add_rdy = $urandom_range(0, 3) != 0;
         add_res_vld = m_q.size() > 0 && $urandom_range(0, 2) == 0;
         add_res = {$urandom, $urandom};
         if ($urandom_range(0, 40) == 0) drain_req = ~drain_req;
         cycle();
         n_vec++;
         if (obs_rdy !== exp_rdy || add_vld !== m_add_vld || (m_add_vld && (add_a !== m_add_a || add_b !== m_add_b))) begin
            n_err++;
            $display("FAIL rand_issue[%0d]: got rdy=%b vld=%b a=%h want rdy=%b vld=%b a=%h",
                     i, obs_rdy, add_vld, add_a, exp_rdy, m_add_vld, m_add_a);
         end
         n_vec++;
         if (rsp_vld !== m_rsp_vld || (m_rsp_vld != '0 && rsp_res !== m_rsp_res) ||
             err !== m_err || drain_ack !== (m_state == 2)) begin
            n_err++;
            $display("FAIL rand_rsp[%0d]: got rsp=%b res=%h err=%b ack=%b want %b %h %b %b",
                     i, rsp_vld, rsp_res, err, drain_ack, m_rsp_vld, m_rsp_res, m_err, m_state == 2);
         end
      end
      drain_req = 1'b0;
      flush_results();
   endtask

   task automatic test_err();
      add_res_vld = 1'b1;
      cycle();
      n_vec++;
      if (err !== 1'b1 || rsp_vld !== '0) begin
         n_err++;
         $display("FAIL err_set: got err=%b rsp=%b want 1 0000", err, rsp_vld);
      end
      add_res_vld = 1'b0;
      repeat (2) cycle();
      n_vec++;
      if (err !== 1'b1) begin
         n_err++;
         $display("FAIL err_sticky: got %b want 1", err);
      end
   endtask

   task automatic test_reset_mid();
      req_vld = '1; add_rdy = 1'b1; drain_req = 1'b0;
      repeat (6) begin
         rand_ops();
         cycle();
      end
      rst = 1'b0;
      #1;
      n_vec++;
      if ({add_vld, rsp_vld, drain_ack, err} !== '0 || add_a !== '0 || add_b !== '0 || rsp_res !== '0) begin
         n_err++;
         $display("FAIL reset_mid: got vld=%b rsp=%b ack=%b err=%b a=%h b=%h r=%h want all 0",
                  add_vld, rsp_vld, drain_ack, err, add_a, add_b, rsp_res);
      end
      model_reset();
      req_vld = '0;
      @(negedge ck);
      rst = 1'b1;
      add_res_vld = 1'b1;
      cycle();
      n_vec++;
      if (err !== 1'b1 || rsp_vld !== '0) begin
         n_err++;
         $display("FAIL reset_discard: got err=%b rsp=%b want 1 0000", err, rsp_vld);
      end
      add_res_vld = 1'b0;
   endtask

   initial begin
      @(negedge ck);
      test_reset();
      test_rr_order();
      test_route();
      test_backpressure();
      test_credit();
      test_drain();
      test_random();
      test_err();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/add_arb.md
ADD_ARB -- requirements
Module: add_arb

Interface
REQ-001 Parameter NREQ, default 4, number of requesters sharing one add_wrap instance (2..8).
REQ-002 Parameter MAX_OUT, default 32, max operations in flight, power of two, depth of tag FIFO.
REQ-003 ck  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  asynchronous reset, active-low (asserted at 0).
REQ-005 req_vld  input  NREQ  per-requester operation valid.
REQ-006 req_a, req_b  input  NREQ*64  per-requester operands; slice i = bits [64*i+63:64*i].
REQ-007 req_rdy  output  NREQ  per-requester grant, at most one bit set.
REQ-008 add_vld, add_a, add_b  output  1/64/64  issue to add_wrap i_vld/i_a/i_b.
REQ-009 add_rdy  input  1  add_wrap o_rdy (entry FIFO not almost full).
REQ-010 add_res_vld, add_res  input  1/64  add_wrap o_vld/o_res.
REQ-011 rsp_vld  output  NREQ  one-hot result strobe; rsp_res  output  64  result, shared by all requesters.
REQ-012 drain_req  input  1  stop issuing, empty pipeline; drain_ack  output  1  pipeline empty.
REQ-013 err  output  1  sticky protocol error.

Function
REQ-014 Transfer from requester i occurs in a cycle where req_vld[i] and req_rdy[i] are both 1.
REQ-015 req_rdy is combinational from req_vld, the priority pointer, add_rdy, credit and state; nonzero only when state RUN, add_rdy=1 and outstanding < MAX_OUT.
REQ-016 Round-robin arbitration: the first requester with req_vld set, searching from pointer ptr upward with wrap NREQ-1 -> 0, is granted; after a grant to i, ptr = (i+1) mod NREQ; ptr is unchanged when no grant.
REQ-017 Accepted operands are registered; add_vld/add_a/add_b appear exactly 1 cycle after transfer; add_vld is 0 in every other cycle.
REQ-018 On each transfer the granted index is pushed into the tag FIFO.
REQ-019 On add_res_vld=1 the tag FIFO is popped; next cycle rsp_vld[tag]=1 and rsp_res=add_res (latency 1); rsp_vld is 0 otherwise; no response backpressure.
REQ-020 outstanding counter (width clog2(MAX_OUT)+1): +1 on transfer, -1 on add_res_vld, unchanged when both occur in the same cycle.
REQ-021 add_res_vld with tag FIFO empty sets err=1, produces no rsp_vld, counter does not underflow; err clears only on reset.
REQ-022 FSM states RUN, DRAIN, DONE; RUN->DRAIN when drain_req=1; DRAIN->DONE when outstanding=0 and no issue register valid; DONE->RUN when drain_req=0.
REQ-023 drain_ack=1 only in DONE; a drain_req asserted in the same cycle as a candidate grant blocks that grant.
REQ-024 Responses continue to be routed in DRAIN and DONE.

Reset
REQ-025 While rst=0: ptr=0, state=RUN, outstanding=0, tag FIFO empty, err=0, add_vld=0, rsp_vld=0, drain_ack=0, add_a/add_b/rsp_res=0.
REQ-026 Reset mid-operation discards all in-flight tags; add_wrap shall be reset in the same reset domain.

Configuration
REQ-027 Macro ADD_ARB_STATS_EN: when defined, output stat_grant (NREQ*32) gives per-requester grant counts, reset to 0, wrapping at 2^32, plus stat_stall (32) counting cycles with any req_vld=1 and req_rdy=0.
REQ-028 Without ADD_ARB_STATS_EN the ports and counters do not exist; all other behaviour is identical.

Structure
REQ-029 Shared package add_arb_pkg holds the FSM state enum, the tag type (clog2(NREQ) bits) and the 64-bit operand type.
REQ-030 One sub-module, add_arb_tagq: synchronous tag FIFO, depth MAX_OUT, push/pop/empty/full; full never reached by construction of REQ-015.

Verification
REQ-031 Reset, then req_vld=4'b1111 held, add_rdy=1 -> grants in order 0,1,2,3,0; add_vld 1 cycle after each.
REQ-032 Requester 2 sends a=1.0, b=2.0; add_res_vld with add_res=3.0 (0x4008000000000000) -> next cycle rsp_vld=4'b0100, rsp_res=0x4008000000000000.
REQ-033 add_rdy=0 with req_vld=4'b0011 -> req_rdy=0, ptr unchanged; add_rdy=1 -> requester at ptr granted.
REQ-034 33 transfers with no results, MAX_OUT=32 -> 32 accepted, req_rdy=0 thereafter; one result -> exactly one more grant.
REQ-035 drain_req=1 with 5 outstanding -> no grants; drain_ack=1 one cycle after outstanding reaches 0; drain_req=0 -> RUN.
REQ-036 add_res_vld with nothing outstanding -> err=1, rsp_vld=0; rst=0 mid-traffic -> all outputs at reset values immediately.
